// File: rtl/tt_um_sample_flow_decoder.sv
// rtl/tt_um_sample_flow_decoder.sv - sample-flow recurrence decoder tile (optional SAMPLE_FLOW_STATS_EN)
module tt_um_sample_flow_decoder #(
    parameter bit          SEED_ZERO  = 1'b1,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        WAIT_SEED = 1'b0,
        TRACK     = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = SEED_ZERO ? TRACK : WAIT_SEED;
    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CNT);

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] x_q, x_d;
    logic       valid_q, valid_d;
    logic       stable_q, stable_d;
    logic [3:0] run_q, run_d;

    logic       sample_valid;
    logic       resync;
    logic [4:0] prev_hi;
    logic [9:0] prev_sq;
    logic [7:0] decoded;
    logic [3:0] run_inc;
    logic       decode_fire;
    logic [2:0] count_bits;
    logic       unused_bits;

    assign sample_valid = uio_in[0];
    assign resync       = uio_in[1];

    // Undo the encoder's update: subtract both prev-derived terms mod 256
    assign prev_hi = prev_q[7:3];
    assign prev_sq = {5'b0, prev_hi} * {5'b0, prev_hi};
    assign decoded = ui_in - {2'b00, prev_q[7:2]} - prev_sq[7:0];

    assign run_inc     = (run_q >= STABLE_MAX) ? STABLE_MAX : run_q + 4'd1;
    assign decode_fire = ena && !resync && sample_valid && (state_q == TRACK);
    assign unused_bits = &{1'b0, uio_in[7:2], prev_sq[9:8]};

    // State and datapath registers; cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RESET_STATE;
            prev_q   <= 8'd0;
            x_q      <= 8'd0;
            valid_q  <= 1'b0;
            stable_q <= 1'b0;
            run_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            stable_q <= stable_d;
            run_q    <= run_d;
        end
    end

    // Next state: seed/track sequencing, decode and stability tracking
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        x_d      = x_q;
        valid_d  = valid_q;
        stable_d = stable_q;
        run_d    = run_q;
        if (ena) begin
            valid_d = 1'b0;
            if (resync) begin
                run_d    = 4'd0;
                stable_d = 1'b0;
                if (sample_valid) begin
                    prev_d  = ui_in;
                    state_d = TRACK;
                end else begin
                    state_d = WAIT_SEED;
                end
            end else if (sample_valid) begin
                prev_d = ui_in;
                if (state_q == WAIT_SEED) begin
                    state_d = TRACK;
                end else begin
                    x_d      = decoded;
                    valid_d  = 1'b1;
                    run_d    = (decoded == x_q && run_q != 4'd0) ? run_inc : 4'd1;
                    stable_d = (run_d >= STABLE_MAX);
                end
            end
        end
    end

`ifdef SAMPLE_FLOW_STATS_EN
    logic [2:0] count_q;

    // Count decoded outputs, wrapping; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
        end else if (decode_fire) begin
            count_q <= count_q + 3'd1;
        end
    end

    assign count_bits = count_q;
`else
    assign count_bits = {2'b00, decode_fire & 1'b0};
`endif

    assign uo_out  = x_q;
    assign uio_out = {count_bits, stable_q, (state_q == TRACK), valid_q, 2'b00};
    assign uio_oe  = 8'b1111_1100;

endmodule
